// File: rtl/instr_sequencer_pkg.sv
// Shared controller definitions for the instruction sequencer: state encoding,
// default instruction-address width and zero constants.
`ifndef INSTR_ADDR_W
`define INSTR_ADDR_W 8
`endif

package instr_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;

  // Wait counter width covers ROM_LAT up to 3.
  localparam int         CNT_W   = 2;
  localparam logic [1:0] GND_CNT = 2'b00;
  localparam logic [2:0] GND_ST  = 3'b000;

endpackage

// File: rtl/instr_sequencer_seq_wait_cnt.sv
// Loadable down-counter with a done flag at zero; paces imem read latency
// and is intended for datapath stall counting as well.
module seq_wait_cnt
  import instr_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer feeding the instruction-fetch register: one program pass per sample.
// Define SEQ_OVERRUN_CHK_EN to add the sticky seq_err output for program-counter overrun.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PCWIDTH    = `INSTR_ADDR_W,
  parameter int PROG_DEPTH = 256,
  parameter int ROM_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               imem_en,
  output logic [PCWIDTH-1:0] imem_addr,
  output logic               fetch,
  input  logic               lstg_f,
  output logic               exec_start,
  input  logic               exec_done,
  output logic               busy,
  output logic               frame_done
`ifdef SEQ_OVERRUN_CHK_EN
  , output logic             seq_err
`endif
);

  localparam logic [PCWIDTH-1:0] PC_LAST   = PCWIDTH'(PROG_DEPTH - 1);
  localparam logic [PCWIDTH-1:0] PC_ZERO   = {PCWIDTH{1'b0}};
  localparam logic [CNT_W-1:0]   WAIT_LOAD = CNT_W'(ROM_LAT - 1);

  logic [2:0]         state_r, state_nx_s;
  logic [PCWIDTH-1:0] pc_r, pc_nx_s;
  logic               last_r;
  logic               frame_end_s;
  logic               wait_done_s, wait_load_s, wait_dec_s;
  logic               sample_ready_r, imem_en_r, fetch_r, exec_start_r, frame_done_r;
`ifdef SEQ_OVERRUN_CHK_EN
  logic               overrun_s;
  logic               seq_err_r;
`endif

  // Next-state and program-counter decode.
  always_comb begin
    state_nx_s  = state_r;
    pc_nx_s     = pc_r;
    frame_end_s = 1'b0;
`ifdef SEQ_OVERRUN_CHK_EN
    overrun_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (sample_valid) state_nx_s = ST_READ;
        else              state_nx_s = ST_IDLE;
      end
      ST_READ: begin
        if (wait_done_s) state_nx_s = ST_FETCH;
        else             state_nx_s = ST_READ;
      end
      ST_FETCH: state_nx_s = ST_START;
      ST_START: state_nx_s = ST_EXEC;
      ST_EXEC: begin
        if (!exec_done) begin
          state_nx_s = ST_EXEC;
        end else if (last_r) begin
          pc_nx_s     = PC_ZERO;
          frame_end_s = 1'b1;
          state_nx_s  = ST_IDLE;
        end else if (pc_r == PC_LAST) begin
          pc_nx_s = PC_ZERO;
`ifdef SEQ_OVERRUN_CHK_EN
          overrun_s  = 1'b1;
          state_nx_s = ST_IDLE;
`else
          state_nx_s = ST_READ;
`endif
        end else begin
          pc_nx_s    = pc_r + PCWIDTH'(1);
          state_nx_s = ST_READ;
        end
      end
      default: begin
        state_nx_s = GND_ST;
        pc_nx_s    = PC_ZERO;
      end
    endcase
  end

  // The read wait is reloaded on every entry into READ.
  assign wait_load_s = (state_nx_s == ST_READ) && (state_r != ST_READ);
  assign wait_dec_s  = (state_r == ST_READ);

  seq_wait_cnt #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load_s),
    .load_val (WAIT_LOAD),
    .dec      (wait_dec_s),
    .done     (wait_done_s)
  );

  // State, pc, last flag, and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      pc_r           <= PC_ZERO;
      last_r         <= 1'b0;
      sample_ready_r <= 1'b1;
      imem_en_r      <= 1'b0;
      fetch_r        <= 1'b0;
      exec_start_r   <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      pc_r           <= pc_nx_s;
      last_r         <= (state_r == ST_START) ? lstg_f : last_r;
      sample_ready_r <= (state_nx_s == ST_IDLE);
      imem_en_r      <= (state_nx_s == ST_READ);
      fetch_r        <= (state_nx_s == ST_FETCH);
      exec_start_r   <= (state_nx_s == ST_START);
      frame_done_r   <= frame_end_s;
    end
  end

`ifdef SEQ_OVERRUN_CHK_EN
  // Overrun flag stays set until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           seq_err_r <= 1'b0;
    else if (overrun_s) seq_err_r <= 1'b1;
    else                seq_err_r <= seq_err_r;
  end
  assign seq_err = seq_err_r;
`endif

  assign sample_ready = sample_ready_r;
  assign busy         = ~sample_ready_r;
  assign imem_en      = imem_en_r;
  assign imem_addr    = pc_r;
  assign fetch        = fetch_r;
  assign exec_start   = exec_start_r;
  assign frame_done   = frame_done_r;

endmodule
